// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector to a combinational
// function, captures its output per vector and compares against EXPECTED.
module truth_table_sweeper #(
    parameter int                N_IN       = 3,
    parameter int                SETTLE_CYC = 1,
    parameter logic [2**N_IN-1:0] EXPECTED  = 8'h41
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [0:N_IN-1]     data_out,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic                match
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [NV-1:0]   table_upd;
    logic            last;
    logic            settled;

    assign last    = (idx == {N_IN{1'b1}});
    assign settled = (cnt == CW'(SETTLE_CYC - 1));

    // Table as it will look after the current sample is written.
    always_comb begin
        table_upd      = table_out;
        table_upd[idx] = f_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settled) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy      = 1'b1;
                state_nxt = last ? DONE : SETTLE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector index, settle counter, capture and compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            data_out  <= '0;
            table_out <= '0;
            match     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= '0;
                        cnt       <= '0;
                        data_out  <= '0;
                        table_out <= '0;
                        match     <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                end
                SAMPLE: begin
                    table_out <= table_upd;
                    if (last) begin
                        match <= (table_upd == EXPECTED);
                    end else begin
                        idx      <= idx + 1'b1;
                        data_out <= idx + 1'b1;
                        cnt      <= '0;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default settle and a 3-cycle
// settle instance, both driven by behavioural function models.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_a, start_a, f_a, busy_a, done_a, match_a;
    logic [0:2] data_a;
    logic [7:0] table_a;
    logic       rst_b, start_b, f_b, busy_b, done_b, match_b;
    logic [0:2] data_b;
    logic [7:0] table_b;
    logic       mode;
    int         ph;
    int         checks = 0;
    int         failures = 0;
    int         n;

    always #5 clk = ~clk;

    // mode 0: ~((x^y)|z); mode 1: faulty ~(x|y|z)
    assign f_a = mode ? ~(data_a[0] | data_a[1] | data_a[2])
                      : ~((data_a[0] ^ data_a[1]) | data_a[2]);

    // Correct only in the 4th cycle of each vector, inverted otherwise.
    assign f_b = ~((data_b[0] ^ data_b[1]) | data_b[2]) ^ (ph != 3);

    truth_table_sweeper u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .data_out(data_a),
        .f_in(f_a), .busy(busy_a), .done(done_a), .table_out(table_a),
        .match(match_a)
    );

    truth_table_sweeper #(.SETTLE_CYC(3)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .data_out(data_b),
        .f_in(f_b), .busy(busy_b), .done(done_b), .table_out(table_b),
        .match(match_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done on instance A, checking the vector sequence and
    // that busy/done are exclusive. Returns edges after the start edge.
    task automatic run_a(output int cyc);
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            if (cyc < 16) check("data_out_step", 32'(data_a), cyc / 2);
            check("busy_not_done", 32'(busy_a & done_a), 0);
            step();
            cyc++;
        end
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; mode = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; ph = 0;
        step();
        step();
        check("rst_data", 32'(data_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_table", 32'(table_a), 0);
        check("rst_match", 32'(match_a), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Correct function, default settle
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("start_busy", 32'(busy_a), 1);
        run_a(n);
        check("latency_16", n, 16);
        check("good_table", 32'(table_a), 32'h41);
        check("good_match", 32'(match_a), 1);
        check("done_busy_low", 32'(busy_a), 0);
        check("done_last_vec", 32'(data_a), 7);
        step();
        check("done_held", 32'(done_a), 1);

        // Faulty function
        mode = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("restart_done_low", 32'(done_a), 0);
        run_a(n);
        check("bad_latency", n, 16);
        check("bad_table", 32'(table_a), 32'h01);
        check("bad_match", 32'(match_a), 0);
        check("bad_done", 32'(done_a), 1);
        mode = 1'b0;

        // SETTLE_CYC=3: sample must be taken on the 4th cycle
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 300) begin
            ph = n % 4;
            if (n < 32) check("b_data_step", 32'(data_b), n / 4);
            step();
            n++;
        end
        ph = 0;
        check("b_latency_32", n, 32);
        check("b_table", 32'(table_b), 32'h41);
        check("b_match", 32'(match_b), 1);

        // start held high through the sweep
        start_a = 1'b1;
        step();
        run_a(n);
        check("held_latency", n, 16);
        check("held_table", 32'(table_a), 32'h41);
        step();
        check("held_restart_done", 32'(done_a), 0);
        check("held_restart_table", 32'(table_a), 0);
        check("held_restart_data", 32'(data_a), 0);
        check("held_restart_busy", 32'(busy_a), 1);
        start_a = 1'b0;
        run_a(n);
        check("held_finish", 32'(done_a), 1);

        // Reset mid-sweep while idx=3
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("mid_idx3", 32'(data_a), 3);
        rst_a = 1'b1;
        step();
        check("midrst_data", 32'(data_a), 0);
        check("midrst_busy", 32'(busy_a), 0);
        check("midrst_done", 32'(done_a), 0);
        check("midrst_table", 32'(table_a), 0);
        check("midrst_match", 32'(match_a), 0);
        rst_a = 1'b0;
        step();
        check("midrst_idle", 32'(busy_a), 0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_a(n);
        check("fresh_latency", n, 16);
        check("fresh_table", 32'(table_a), 32'h41);
        check("fresh_match", 32'(match_a), 1);

        // rst and start together
        rst_a = 1'b1;
        start_a = 1'b1;
        step();
        check("rst_start_busy", 32'(busy_a), 0);
        check("rst_start_done", 32'(done_a), 0);
        rst_a = 1'b0;
        start_a = 1'b0;
        step();
        check("rst_start_forgot", 32'(busy_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
